tx_slot_scheduler: RTL and testbench
====================================

// Module: tx_slot_scheduler
// PURPOSE
//  TDMA slot timer and burst arbiter in front of the GMSK burst transmitter. Counts modulator
//  symbol strobes into slots/frames, picks one of two requesters per slot via per-requester
//  slot masks, and pulses fire_burst at a fixed offset when the transmitter reports armed.
//  Tracks burst completion via iq_valid, enforces one burst per slot, flags missed slots.
// PARAMETERS
//  SLOT_SYMBOLS     156  symbol strobes per slot (>=FIRE_OFFSET+2)
//  SLOTS_PER_FRAME  8    slots per frame; slot index width SW=$clog2(SLOTS_PER_FRAME)
//  FIRE_OFFSET      4    symbol index within slot at which fire_burst is issued
//  BURST_TIMEOUT    152  symbols after fire before a burst is declared hung
// PORTS
//  clock          in   1   system clock
//  reset_n        in   1   asynchronous active-low reset
//  enable         in   1   0: no new grants/fires; counters keep running
//  symbol_strobe  in   1   modulator symbol_input_strobe; one-cycle-or-longer high level
//  tx_armed       in   1   transmitter is_armed
//  tx_iq_valid    in   1   transmitter iq_valid (PA enable)
//  fire_burst     out  1   one-cycle pulse to transmitter
//  slot_mask0     in   SLOTS_PER_FRAME  slots requester 0 may use (bit n = slot n)
//  slot_mask1     in   SLOTS_PER_FRAME  slots requester 1 may use
//  req_valid      in   2   requester n has a burst pending (level, held until grant)
//  req_grant      out  2   one-hot one-cycle pulse, same cycle as fire_burst
//  tx_owner       out  1   requester owning the current/last burst
//  slot_index     out  SW  current slot number
//  frame_count    out  8   frame number, wraps 255->0
//  busy           out  1   high from fire_burst until burst completes or times out
//  missed_slot    out  1   one-cycle pulse: slot selected but tx_armed low at fire point
//  burst_timeout  out  1   one-cycle pulse: burst exceeded BURST_TIMEOUT
// BEHAVIOUR
//  Reset: all outputs 0; symbol counter, slot_index, frame_count 0; FSM IDLE; rr pointer 0.
//  Strobe edge: symbol tick = rising edge of symbol_strobe (registered previous value); a level
//   held many cycles counts once. All counting below is in ticks.
//  Counters: sym 0..SLOT_SYMBOLS-1; at wrap slot_index++; at slot wrap frame_count++ (mod 256).
//  FSM IDLE: at tick with sym==0 (slot start): eligible[n]=req_valid[n]&slot_mask_n[slot_index]
//   &enable. None -> stay IDLE. Else latch winner -> SELECTED.
//  Arbitration: fixed priority, requester 0 wins ties (see CONFIGURATION).
//  SELECTED: at tick where sym==FIRE_OFFSET: if tx_armed -> next cycle fire_burst=1,
//   req_grant[owner]=1, tx_owner=owner, busy=1 -> ACTIVE. If tx_armed=0 -> missed_slot pulse,
//   no grant (request stays pending) -> IDLE. enable dropping in SELECTED -> IDLE, no pulse.
//  ACTIVE: wait for tx_iq_valid rising, then falling -> DONE. Timeout counter counts ticks from
//   fire; reaching BURST_TIMEOUT before the fall -> burst_timeout pulse -> DONE.
//  DONE: busy=0 next cycle; -> IDLE. Earliest next fire is the next slot; a burst crossing a slot
//   start makes that slot ineligible (arbitration only sampled in IDLE).
//  Simultaneous: slot-start tick with both eligible -> one grant only; loser waits for later slot.
//   Requester dropping req_valid after selection still receives its grant pulse if fired.
//  Reset mid-burst: FSM/counters clear asynchronously; fire_burst/busy/grants drop immediately.
//  Latency: fire_burst asserts exactly 1 clock after the FIRE_OFFSET tick edge is detected.
// CONFIGURATION
//  TX_SCHED_RR_EN defined: round-robin on ties; pointer toggles to the non-winner after each
//   granted burst (not on misses/timeouts); pointer starts at 0 after reset.
//  Undefined: fixed priority, requester 0 always wins ties; no pointer state.
// TESTING
//  1 req_valid=01, mask0=8'h01, tx_armed=1 -> fire_burst+req_grant=01 at slot 0 sym 4, none
//    in slots 1..7; busy clears on iq_valid fall.
//  2 req_valid=11, both masks 8'hFF, armed, 4 slots -> fixed: grants 01 every slot;
//    with TX_SCHED_RR_EN: 01,10,01,10.
//  3 tx_armed=0 at sym 4 of selected slot -> missed_slot pulse, no grant; armed next slot -> fires.
//  4 tx_iq_valid never falls -> burst_timeout pulse 152 ticks after fire; busy drops; IDLE.
//  5 8*156 ticks -> frame_count 1; 256 frames -> frame_count 0, slot_index 0.
//  6 reset_n low mid-ACTIVE -> busy/fire/grant 0 same cycle, counters 0; after release, slot 0 fires.

Source files
------------

// File: rtl/tx_slot_scheduler.sv
// tx_slot_scheduler: TDMA slot timer and two-requester burst arbiter that sits in
// front of the GMSK burst transmitter. Symbol strobes are counted into slots and
// frames; one requester is chosen at each slot start and fire_burst is issued at
// a fixed symbol offset if the transmitter is armed.
// Build option: define TX_SCHED_RR_EN for round-robin tie breaking; otherwise
// requester 0 always wins ties.
module tx_slot_scheduler #(
  parameter int SLOT_SYMBOLS    = 156,
  parameter int SLOTS_PER_FRAME = 8,
  parameter int FIRE_OFFSET     = 4,
  parameter int BURST_TIMEOUT   = 152,
  localparam int SW = (SLOTS_PER_FRAME > 1) ? $clog2(SLOTS_PER_FRAME) : 1
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       enable,
  input  logic                       symbol_strobe,
  input  logic                       tx_armed,
  input  logic                       tx_iq_valid,
  output logic                       fire_burst,
  input  logic [SLOTS_PER_FRAME-1:0] slot_mask0,
  input  logic [SLOTS_PER_FRAME-1:0] slot_mask1,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_grant,
  output logic                       tx_owner,
  output logic [SW-1:0]              slot_index,
  output logic [7:0]                 frame_count,
  output logic                       busy,
  output logic                       missed_slot,
  output logic                       burst_timeout
);

  localparam int SYM_W = (SLOT_SYMBOLS > 1) ? $clog2(SLOT_SYMBOLS) : 1;
  localparam int TO_W  = $clog2(BURST_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, SELECTED, ACTIVE, DONE} state_t;

  state_t           state;
  logic             strobe_p0;
  logic [SYM_W-1:0] sym;
  logic [TO_W-1:0]  to_cnt;
  logic             iq_seen;
  logic             owner_sel;
  logic             tick;
  logic             slot_start;
  logic             fire_point;
  logic             fire_go;
  logic [1:0]       eligible;
  logic             winner;
`ifdef TX_SCHED_RR_EN
  logic             rr_ptr;
`endif

  // A held strobe level counts once: only its rising edge is a symbol tick.
  assign tick       = symbol_strobe & ~strobe_p0;
  assign slot_start = tick & (sym == '0);
  assign fire_point = tick & (sym == SYM_W'(FIRE_OFFSET));
  assign fire_go    = (state == SELECTED) & enable & fire_point & tx_armed;

  // Symbol / slot / frame counters; they free-run regardless of enable.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      strobe_p0   <= 1'b0;
      sym         <= '0;
      slot_index  <= '0;
      frame_count <= '0;
    end else begin
      strobe_p0 <= symbol_strobe;
      if (tick) begin
        if (sym == SYM_W'(SLOT_SYMBOLS - 1)) begin
          sym <= '0;
          if (slot_index == SW'(SLOTS_PER_FRAME - 1)) begin
            slot_index  <= '0;
            frame_count <= frame_count + 8'd1;
          end else begin
            slot_index <= slot_index + SW'(1);
          end
        end else begin
          sym <= sym + SYM_W'(1);
        end
      end
    end
  end

  // Eligibility for the current slot and the tie-break winner.
  always_comb begin
    eligible[0] = req_valid[0] & slot_mask0[slot_index] & enable;
    eligible[1] = req_valid[1] & slot_mask1[slot_index] & enable;
`ifdef TX_SCHED_RR_EN
    if (&eligible) winner = rr_ptr;
    else           winner = ~eligible[0];
`else
    winner = ~eligible[0];
`endif
  end

`ifdef TX_SCHED_RR_EN
  // Tie-break pointer moves to the losing requester after each burst actually fired.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)     rr_ptr <= 1'b0;
    else if (fire_go) rr_ptr <= ~owner_sel;
  end
`endif

  // Slot FSM: select at slot start, fire at the offset, then supervise the burst.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      owner_sel     <= 1'b0;
      to_cnt        <= '0;
      iq_seen       <= 1'b0;
      fire_burst    <= 1'b0;
      req_grant     <= 2'b00;
      tx_owner      <= 1'b0;
      busy          <= 1'b0;
      missed_slot   <= 1'b0;
      burst_timeout <= 1'b0;
    end else begin
      fire_burst    <= 1'b0;
      req_grant     <= 2'b00;
      missed_slot   <= 1'b0;
      burst_timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (slot_start && (|eligible)) begin
            owner_sel <= winner;
            state     <= SELECTED;
          end
        end
        SELECTED: begin
          if (!enable) begin
            state <= IDLE;
          end else if (fire_point) begin
            if (tx_armed) begin
              fire_burst <= 1'b1;
              req_grant  <= owner_sel ? 2'b10 : 2'b01;
              tx_owner   <= owner_sel;
              busy       <= 1'b1;
              to_cnt     <= '0;
              iq_seen    <= 1'b0;
              state      <= ACTIVE;
            end else begin
              // Request is left pending; it competes again at a later slot.
              missed_slot <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        ACTIVE: begin
          if (tx_iq_valid) iq_seen <= 1'b1;
          if (iq_seen && !tx_iq_valid) begin
            busy  <= 1'b0;
            state <= DONE;
          end else if (tick) begin
            if (to_cnt == TO_W'(BURST_TIMEOUT - 1)) begin
              burst_timeout <= 1'b1;
              busy          <= 1'b0;
              state         <= DONE;
            end else begin
              to_cnt <= to_cnt + TO_W'(1);
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_slot_scheduler.sv
// Self-checking bench for tx_slot_scheduler: a per-slot vector table, hand-written
// sequences for latency, timeout, enable drop, reset mid-burst and frame wrap, and
// an event scoreboard that matches every fire/miss/timeout pulse to an expectation.
module tb_tx_slot_scheduler;

  localparam int SLOT_SYMBOLS = 156;
  localparam int FIRE_OFFSET  = 4;
  localparam int S_SLOT       = 6;   // compact instance used for the 256-frame wrap
  localparam int NV           = 14;
`ifdef TX_SCHED_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {EV_NONE, EV_FIRE, EV_MISS, EV_TIMEOUT} ev_kind_t;
  typedef struct packed {
    ev_kind_t    kind;
    logic [1:0]  grant;
    logic [31:0] slot;
    logic [31:0] at_tick;
  } ev_t;
  typedef struct packed {
    logic [1:0] req;
    logic [7:0] m0;
    logic [7:0] m1;
    logic       armed;
    logic       en;
    ev_kind_t   kind;
    logic [1:0] grant;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0, symbol_strobe = 1'b0, tx_armed = 1'b0;
  logic       iq_force = 1'b0, iq_auto = 1'b0, iq_auto_lvl;
  logic       tx_iq_valid;
  logic [7:0] slot_mask0 = 8'h00, slot_mask1 = 8'h00;
  logic [1:0] req_valid = 2'b00;
  logic       fire_burst, tx_owner, busy, missed_slot, burst_timeout;
  logic [1:0] req_grant;
  logic [2:0] slot_index;
  logic [7:0] frame_count;
  logic       s_fire, s_owner, s_busy, s_missed, s_to;
  logic [1:0] s_grant;
  logic [2:0] s_slot;
  logic [7:0] s_frame;

  int   checks = 0, failures = 0;
  int   m_ticks = 0, m_sym = 0, m_slot = 0, m_frame = 0;
  int   base;
  ev_t  exp_q[$];
  vec_t vecs [NV];

  assign tx_iq_valid = iq_force | iq_auto_lvl;

  always #5 clock = ~clock;

  tx_slot_scheduler dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .symbol_strobe(symbol_strobe),
    .tx_armed(tx_armed), .tx_iq_valid(tx_iq_valid), .fire_burst(fire_burst),
    .slot_mask0(slot_mask0), .slot_mask1(slot_mask1), .req_valid(req_valid),
    .req_grant(req_grant), .tx_owner(tx_owner), .slot_index(slot_index),
    .frame_count(frame_count), .busy(busy), .missed_slot(missed_slot),
    .burst_timeout(burst_timeout)
  );

  tx_slot_scheduler #(.SLOT_SYMBOLS(S_SLOT), .SLOTS_PER_FRAME(8), .FIRE_OFFSET(4),
                      .BURST_TIMEOUT(4)) dut_small (
    .clock(clock), .reset_n(reset_n), .enable(enable), .symbol_strobe(symbol_strobe),
    .tx_armed(tx_armed), .tx_iq_valid(tx_iq_valid), .fire_burst(s_fire),
    .slot_mask0(slot_mask0), .slot_mask1(slot_mask1), .req_valid(2'b00),
    .req_grant(s_grant), .tx_owner(s_owner), .slot_index(s_slot),
    .frame_count(s_frame), .busy(s_busy), .missed_slot(s_missed),
    .burst_timeout(s_to)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic adv_model();
    if (m_sym == SLOT_SYMBOLS - 1) begin
      m_sym = 0;
      if (m_slot == 7) begin
        m_slot  = 0;
        m_frame = (m_frame + 1) % 256;
      end else begin
        m_slot++;
      end
    end else begin
      m_sym++;
    end
  endtask

  task automatic do_tick(input int hold);
    symbol_strobe = 1'b1;
    m_ticks++;
    repeat (hold) cycle();
    symbol_strobe = 1'b0;
    cycle();
    adv_model();
  endtask

  task automatic run_ticks(input int n);
    for (int i = 0; i < n; i++) do_tick(1);
  endtask

  task automatic push_ev(input ev_kind_t k, input logic [1:0] g, input int slot, input int at);
    ev_t e;
    e.kind = k; e.grant = g; e.slot = 32'(slot); e.at_tick = 32'(at);
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    m_sym = 0; m_slot = 0; m_frame = 0;
    cycle();
  endtask

  // Transmitter stand-in: after each fire, iq_valid rises for a short burst.
  initial begin
    iq_auto_lvl = 1'b0;
    forever begin
      cycle();
      if (fire_burst && iq_auto) begin
        repeat (3) cycle();
        iq_auto_lvl = 1'b1;
        repeat (20) cycle();
        iq_auto_lvl = 1'b0;
      end
    end
  end

  // Scoreboard: every output pulse must match the oldest pending expectation.
  always @(negedge clock) begin : monitor
    ev_t e;
    if (reset_n && (fire_burst || missed_slot || burst_timeout)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual fire=%0b miss=%0b timeout=%0b tick=%0d required=none",
                 fire_burst, missed_slot, burst_timeout, m_ticks);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", fire_burst ? EV_FIRE : (missed_slot ? EV_MISS : EV_TIMEOUT), e.kind);
        check("event_single", 32'(fire_burst) + 32'(missed_slot) + 32'(burst_timeout), 1);
        check("event_tick", m_ticks, e.at_tick);
        check("event_slot", slot_index, e.slot);
        check("event_grant", req_grant, e.grant);
        if (e.kind == EV_FIRE) begin
          check("fire_owner", tx_owner, e.grant[1]);
          check("fire_busy", busy, 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{2'b11, 8'hFF, 8'hFF, 1'b1, 1'b1, EV_FIRE, 2'b01};
    vecs[1]  = '{2'b11, 8'hFF, 8'hFF, 1'b1, 1'b1, EV_FIRE, RR_EN ? 2'b10 : 2'b01};
    vecs[2]  = '{2'b11, 8'hFF, 8'hFF, 1'b1, 1'b1, EV_FIRE, 2'b01};
    vecs[3]  = '{2'b11, 8'hFF, 8'hFF, 1'b1, 1'b1, EV_FIRE, RR_EN ? 2'b10 : 2'b01};
    vecs[4]  = '{2'b01, 8'h01, 8'h00, 1'b1, 1'b1, EV_NONE, 2'b00};
    vecs[5]  = '{2'b10, 8'hFF, 8'h20, 1'b1, 1'b1, EV_FIRE, 2'b10};
    vecs[6]  = '{2'b10, 8'hFF, 8'h20, 1'b1, 1'b1, EV_NONE, 2'b00};
    vecs[7]  = '{2'b11, 8'hFF, 8'hFF, 1'b1, 1'b0, EV_NONE, 2'b00};
    vecs[8]  = '{2'b01, 8'h01, 8'h00, 1'b1, 1'b1, EV_FIRE, 2'b01};
    vecs[9]  = '{2'b11, 8'hFF, 8'hFF, 1'b0, 1'b1, EV_MISS, 2'b00};
    vecs[10] = '{2'b11, 8'hFF, 8'hFF, 1'b1, 1'b1, EV_FIRE, RR_EN ? 2'b10 : 2'b01};
    vecs[11] = '{2'b10, 8'hFF, 8'h00, 1'b1, 1'b1, EV_NONE, 2'b00};
    vecs[12] = '{2'b11, 8'h00, 8'h10, 1'b1, 1'b1, EV_FIRE, 2'b10};
    vecs[13] = '{2'b11, 8'h20, 8'h20, 1'b1, 1'b1, EV_FIRE, 2'b01};

    // Reset state
    repeat (2) cycle();
    check("rst_fire", fire_burst, 0);
    check("rst_grant", req_grant, 0);
    check("rst_owner", tx_owner, 0);
    check("rst_slot", slot_index, 0);
    check("rst_frame", frame_count, 0);
    check("rst_busy", busy, 0);
    check("rst_missed", missed_slot, 0);
    check("rst_timeout", burst_timeout, 0);
    reset_n = 1'b1;
    cycle();

    // Single requester in slot 0, long strobe levels, exact fire latency, one frame
    req_valid = 2'b01; slot_mask0 = 8'h01; slot_mask1 = 8'h00;
    tx_armed = 1'b1; enable = 1'b1; iq_auto = 1'b1;
    push_ev(EV_FIRE, 2'b01, 0, m_ticks + 1 + FIRE_OFFSET);
    for (int i = 0; i < FIRE_OFFSET; i++) do_tick(3);
    symbol_strobe = 1'b1;
    m_ticks++;
    cycle();
    check("fire_latency", fire_burst, 1);
    check("fire_grant01", req_grant, 2'b01);
    cycle();
    check("fire_width", fire_burst, 0);
    check("grant_width", req_grant, 0);
    repeat (2) cycle();
    symbol_strobe = 1'b0;
    cycle();
    adv_model();
    run_ticks(SLOT_SYMBOLS - FIRE_OFFSET - 1 + 7 * SLOT_SYMBOLS);
    check("frame1_count", frame_count, 1);
    check("frame1_slot", slot_index, 0);
    check("frame1_busy", busy, 0);
    check("frame1_drained", exp_q.size(), 0);

    // Per-slot vector table
    do_reset();
    for (int i = 0; i < NV; i++) begin
      req_valid  = vecs[i].req;
      slot_mask0 = vecs[i].m0;
      slot_mask1 = vecs[i].m1;
      tx_armed   = vecs[i].armed;
      enable     = vecs[i].en;
      if (vecs[i].kind != EV_NONE)
        push_ev(vecs[i].kind, vecs[i].grant, m_slot, m_ticks + 1 + FIRE_OFFSET);
      run_ticks(SLOT_SYMBOLS);
      check($sformatf("vec%0d_drained", i), exp_q.size(), 0);
      check($sformatf("vec%0d_busy", i), busy, 0);
      check($sformatf("vec%0d_slot", i), slot_index, m_slot);
    end

    // Hung burst: timeout, slot crossed by the burst is skipped, next slot fires
    do_reset();
    iq_auto = 1'b0;
    req_valid = 2'b01; slot_mask0 = 8'hFF; slot_mask1 = 8'h00; tx_armed = 1'b1; enable = 1'b1;
    base = m_ticks;
    push_ev(EV_FIRE, 2'b01, 0, base + 1 + FIRE_OFFSET);
    run_ticks(FIRE_OFFSET + 1);
    iq_force = 1'b1;
    push_ev(EV_TIMEOUT, 2'b00, 1, base + 1 + FIRE_OFFSET + 152);
    run_ticks(151);
    check("hung_busy", busy, 1);
    check("hung_pending", exp_q.size(), 1);
    run_ticks(1);
    check("timeout_busy", busy, 0);
    check("timeout_drained", exp_q.size(), 0);
    iq_force = 1'b0;
    iq_auto = 1'b1;
    push_ev(EV_FIRE, 2'b01, 2, base + 2 * SLOT_SYMBOLS + 1 + FIRE_OFFSET);
    run_ticks(3 * SLOT_SYMBOLS - (FIRE_OFFSET + 1 + 152));
    check("after_timeout_drained", exp_q.size(), 0);

    // enable drops while a request is selected: no fire, no miss; fires next slot
    run_ticks(2);
    enable = 1'b0;
    run_ticks(SLOT_SYMBOLS - 2);
    enable = 1'b1;
    push_ev(EV_FIRE, 2'b01, 4, m_ticks + 1 + FIRE_OFFSET);
    run_ticks(SLOT_SYMBOLS);
    check("enable_drop_drained", exp_q.size(), 0);

    // Reset asserted while fire_burst is high
    iq_auto = 1'b0;
    run_ticks(FIRE_OFFSET);
    symbol_strobe = 1'b1;
    m_ticks++;
    cycle();
    check("pre_reset_fire", fire_burst, 1);
    #1 reset_n = 1'b0;
    #1;
    check("async_fire", fire_burst, 0);
    check("async_grant", req_grant, 0);
    check("async_busy", busy, 0);
    check("async_slot", slot_index, 0);
    symbol_strobe = 1'b0;
    repeat (2) cycle();
    reset_n = 1'b1;
    m_sym = 0; m_slot = 0; m_frame = 0;
    cycle();
    iq_auto = 1'b1;
    push_ev(EV_FIRE, 2'b01, 0, m_ticks + 1 + FIRE_OFFSET);
    run_ticks(SLOT_SYMBOLS);
    check("post_reset_drained", exp_q.size(), 0);

    // 256-frame wrap on the compact instance; main counters follow the model
    do_reset();
    req_valid = 2'b00;
    run_ticks(256 * 8 * S_SLOT - 1);
    check("wrap_frame255", s_frame, 255);
    check("wrap_slot7", s_slot, 7);
    run_ticks(1);
    check("wrap_frame0", s_frame, 0);
    check("wrap_slot0", s_slot, 0);
    check("model_slot", slot_index, m_slot);
    check("model_frame", frame_count, m_frame);
    check("small_idle", {s_fire, s_grant, s_owner, s_busy, s_missed, s_to}, 0);
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
